// File: rtl/iomem_pkg.sv
// Shared types and constants for the iomem bus arbiter and its helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package iomem_pkg;

    localparam int unsigned IOMEM_AW = 32;
    localparam int unsigned IOMEM_DW = 32;
    localparam int unsigned IOMEM_SW = 4;

    // Peripheral base: the upper address byte selects the peripheral.
    localparam logic [7:0] GPIO_BASE = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_GNT0 = 3'd1,
        ST_GNT1 = 3'd2,
        ST_ERR0 = 3'd3,
        ST_ERR1 = 3'd4
    } iomem_state_e;

    // Request payload that travels alongside a valid.
    typedef struct packed {
        logic [IOMEM_AW-1:0] addr;
        logic [IOMEM_DW-1:0] wdata;
        logic [IOMEM_SW-1:0] wstrb;
    } iomem_req_t;

endpackage

// File: rtl/iomem_watchdog.sv
// Stall watchdog: counts enabled cycles and flags the cycle that would reach the limit.
// Latency: expired is combinational from the count and en.
// Backpressure: none; the count saturates at the limit, and a limit of 0 never expires.
module iomem_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Saturating stall counter, zeroed whenever the owner is not waiting.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LIMIT)) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Fire in the stalled cycle whose increment would reach the limit, so the
    // owner can hand over to its error state without spending one more cycle.
    assign expired = (TIMEOUT_CYCLES != 0) && en && (cnt == LAST);

endmodule

// File: rtl/iomem_arbiter.sv
// Two-master round-robin arbiter onto one iomem slave, with a stall watchdog.
// Latency: one cycle from request in IDLE to s_valid; ready is passed through combinationally.
// Backpressure: a master waits on ready; a stalled slave is cut off with an error word.
module iomem_arbiter
    import iomem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                m0_valid,
    output logic                m0_ready,
    input  logic [IOMEM_AW-1:0] m0_addr,
    input  logic [IOMEM_DW-1:0] m0_wdata,
    input  logic [IOMEM_SW-1:0] m0_wstrb,
    output logic [IOMEM_DW-1:0] m0_rdata,
    input  logic                m1_valid,
    output logic                m1_ready,
    input  logic [IOMEM_AW-1:0] m1_addr,
    input  logic [IOMEM_DW-1:0] m1_wdata,
    input  logic [IOMEM_SW-1:0] m1_wstrb,
    output logic [IOMEM_DW-1:0] m1_rdata,
    output logic                s_valid,
    input  logic                s_ready,
    output logic [IOMEM_AW-1:0] s_addr,
    output logic [IOMEM_DW-1:0] s_wdata,
    output logic [IOMEM_SW-1:0] s_wstrb,
    input  logic [IOMEM_DW-1:0] s_rdata,
    output logic                timeout_flag,
    output logic                timeout_master,
    input  logic                timeout_clr
);

    iomem_state_e state_q, state_d;
    logic         last_grant_q;
    logic         in_gnt;
    logic         wd_expired;
    iomem_req_t   m0_req, m1_req, s_req;

    assign m0_req = '{addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
    assign m1_req = '{addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};

    assign s_addr  = s_req.addr;
    assign s_wdata = s_req.wdata;
    assign s_wstrb = s_req.wstrb;

    assign in_gnt = (state_q == ST_GNT0) || (state_q == ST_GNT1);

    iomem_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .resetn (resetn),
        .clr    (!in_gnt),
        .en     (in_gnt && !s_ready),
        .expired(wd_expired)
    );

    // State, round-robin pointer and sticky timeout status.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            last_grant_q   <= 1'b1;
            timeout_flag   <= 1'b0;
            timeout_master <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && state_d == ST_GNT0) begin
                last_grant_q <= 1'b0;
            end else if (state_q == ST_IDLE && state_d == ST_GNT1) begin
                last_grant_q <= 1'b1;
            end
            // A timeout landing together with a clear must not be lost.
            if (state_q == ST_ERR0 || state_q == ST_ERR1) begin
                timeout_flag   <= 1'b1;
                timeout_master <= (state_q == ST_ERR1);
            end else if (timeout_clr) begin
                timeout_flag <= 1'b0;
            end
        end
    end

    // Next-state decode and the request/response muxes for the current owner.
    always_comb begin
        state_d  = state_q;
        s_valid  = 1'b0;
        s_req    = '0;
        m0_ready = 1'b0;
        m0_rdata = '0;
        m1_ready = 1'b0;
        m1_rdata = '0;
        case (state_q)
            ST_IDLE: begin
                if (m0_valid && (!m1_valid || last_grant_q)) begin
                    state_d = ST_GNT0;
                end else if (m1_valid) begin
                    state_d = ST_GNT1;
                end
            end
            ST_GNT0: begin
                s_valid  = m0_valid;
                s_req    = m0_req;
                m0_ready = s_ready && m0_valid;
                m0_rdata = s_rdata;
                if (!m0_valid || s_ready) begin
                    state_d = ST_IDLE;
                end else if (wd_expired) begin
                    state_d = ST_ERR0;
                end
            end
            ST_GNT1: begin
                s_valid  = m1_valid;
                s_req    = m1_req;
                m1_ready = s_ready && m1_valid;
                m1_rdata = s_rdata;
                if (!m1_valid || s_ready) begin
                    state_d = ST_IDLE;
                end else if (wd_expired) begin
                    state_d = ST_ERR1;
                end
            end
            ST_ERR0: begin
                m0_ready = 1'b1;
                m0_rdata = ERR_RDATA;
                state_d  = ST_IDLE;
            end
            ST_ERR1: begin
                m1_ready = 1'b1;
                m1_rdata = ERR_RDATA;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_iomem_arbiter.sv
// Directed bench for iomem_arbiter with the watchdog shortened to 8 cycles.
// Latency: inputs driven 1 time unit after posedge, outputs sampled 1 unit later.
// Backpressure: the bench plays the slave and decides when s_ready pulses.
module tb_iomem_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_valid, m0_ready, m1_valid, m1_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
    logic        s_valid, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        timeout_flag, timeout_master, timeout_clr;
    logic [31:0] slave_reg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iomem_arbiter #(
        .TIMEOUT_CYCLES(8),
        .ERR_RDATA     (32'hDEAD_BEEF)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .m0_valid      (m0_valid),
        .m0_ready      (m0_ready),
        .m0_addr       (m0_addr),
        .m0_wdata      (m0_wdata),
        .m0_wstrb      (m0_wstrb),
        .m0_rdata      (m0_rdata),
        .m1_valid      (m1_valid),
        .m1_ready      (m1_ready),
        .m1_addr       (m1_addr),
        .m1_wdata      (m1_wdata),
        .m1_wstrb      (m1_wstrb),
        .m1_rdata      (m1_rdata),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_addr        (s_addr),
        .s_wdata       (s_wdata),
        .s_wstrb       (s_wstrb),
        .s_rdata       (s_rdata),
        .timeout_flag  (timeout_flag),
        .timeout_master(timeout_master),
        .timeout_clr   (timeout_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL bench_timeout got stuck exp finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; timeout_clr = 1'b0;
        m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        s_ready = 1'b0; s_rdata = '0; slave_reg = '0;

        // Reset state
        repeat (3) tick();
        #1;
        chk("rst_s_valid", s_valid, 0);
        chk("rst_m0_ready", m0_ready, 0);
        chk("rst_m1_ready", m1_ready, 0);
        chk("rst_m0_rdata", m0_rdata, 0);
        chk("rst_tflag", timeout_flag, 0);
        chk("rst_tmaster", timeout_master, 0);

        // Single read by m0, slave answers two cycles after s_valid
        tick();
        resetn = 1'b1;
        m0_valid = 1'b1; m0_addr = 32'h0300_0000; m0_wstrb = 4'h0;
        #1;
        chk("t1_idle_s_valid", s_valid, 0);
        tick(); #1;
        chk("t1_g1_s_valid", s_valid, 1);
        chk("t1_g1_s_addr", s_addr, 32'h0300_0000);
        chk("t1_g1_s_wstrb", s_wstrb, 0);
        chk("t1_g1_m0_ready", m0_ready, 0);
        tick(); #1;
        chk("t1_g2_s_valid", s_valid, 1);
        chk("t1_g2_m0_ready", m0_ready, 0);
        tick();
        s_ready = 1'b1; s_rdata = 32'h1234_5678;
        #1;
        chk("t1_m0_ready", m0_ready, 1);
        chk("t1_m0_rdata", m0_rdata, 32'h1234_5678);
        chk("t1_m1_ready", m1_ready, 0);
        tick();
        s_ready = 1'b0; s_rdata = '0; m0_valid = 1'b0;
        #1;
        chk("t1_post_s_valid", s_valid, 0);
        chk("t1_post_m0_ready", m0_ready, 0);

        // Simultaneous requests right after reset: m0, then m1, then m0
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        m0_valid = 1'b1; m0_addr = 32'h0300_0004;
        m1_valid = 1'b1; m1_addr = 32'h0300_0008;
        tick(); #1;
        chk("t2_a_s_addr", s_addr, 32'h0300_0004);
        s_ready = 1'b1; s_rdata = 32'h0000_0011;
        #1;
        chk("t2_a_m0_ready", m0_ready, 1);
        chk("t2_a_m1_ready", m1_ready, 0);
        chk("t2_a_m1_rdata", m1_rdata, 0);
        tick();
        s_ready = 1'b0;
        #1;
        chk("t2_idle_s_valid", s_valid, 0);
        tick(); #1;
        chk("t2_b_s_addr", s_addr, 32'h0300_0008);
        s_ready = 1'b1; s_rdata = 32'h0000_0022;
        #1;
        chk("t2_b_m1_ready", m1_ready, 1);
        chk("t2_b_m1_rdata", m1_rdata, 32'h0000_0022);
        chk("t2_b_m0_ready", m0_ready, 0);
        tick();
        s_ready = 1'b0;
        tick(); #1;
        chk("t2_c_s_addr", s_addr, 32'h0300_0004);
        s_ready = 1'b1;
        #1;
        chk("t2_c_m0_ready", m0_ready, 1);
        tick();
        s_ready = 1'b0; m0_valid = 1'b0; m1_valid = 1'b0;

        // Write forwarding from m1 with a partial strobe
        m1_valid = 1'b1; m1_addr = 32'h0300_0010;
        m1_wdata = 32'hA5A5_A5A5; m1_wstrb = 4'b0011;
        tick(); #1;
        chk("t3_s_addr", s_addr, 32'h0300_0010);
        chk("t3_s_wdata", s_wdata, 32'hA5A5_A5A5);
        chk("t3_s_wstrb", s_wstrb, 32'h3);
        s_ready = 1'b1;
        #1;
        chk("t3_m1_ready", m1_ready, 1);
        chk("t3_m0_ready", m0_ready, 0);
        for (int b = 0; b < 4; b++) begin
            if (s_wstrb[b]) slave_reg[b*8 +: 8] = s_wdata[b*8 +: 8];
        end
        chk("t3_slave_reg", slave_reg, 32'h0000_A5A5);
        tick();
        s_ready = 1'b0; m1_valid = 1'b0; m1_wstrb = 4'h0;

        // Watchdog expiry on an m0 read
        m0_valid = 1'b1; m0_addr = 32'h0300_0020;
        tick();
        for (int k = 1; k <= 8; k++) begin
            #1;
            chk($sformatf("t4_wait%0d", k), {m0_ready, s_valid}, 32'h1);
            tick();
        end
        #1;
        chk("t4_m0_ready", m0_ready, 1);
        chk("t4_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("t4_err_s_valid", s_valid, 0);
        m0_valid = 1'b0;
        tick(); #1;
        chk("t4_tflag", timeout_flag, 1);
        chk("t4_tmaster", timeout_master, 0);
        timeout_clr = 1'b1;
        tick();
        timeout_clr = 1'b0;
        #1;
        chk("t4_tflag_clr", timeout_flag, 0);

        // Watchdog expiry on m1 while clear is held: set beats clear
        m1_valid = 1'b1; m1_addr = 32'h0300_0024; timeout_clr = 1'b1;
        tick();
        repeat (8) tick();
        #1;
        chk("t4b_m1_ready", m1_ready, 1);
        chk("t4b_m1_rdata", m1_rdata, 32'hDEAD_BEEF);
        chk("t4b_m0_ready", m0_ready, 0);
        m1_valid = 1'b0;
        tick(); #1;
        chk("t4b_tflag", timeout_flag, 1);
        chk("t4b_tmaster", timeout_master, 1);
        tick();
        timeout_clr = 1'b0;
        #1;
        chk("t4b_tflag_clr", timeout_flag, 0);
        chk("t4b_tmaster_keep", timeout_master, 1);

        // s_ready arrives in the expiry cycle: normal completion wins
        m0_valid = 1'b1; m0_addr = 32'h0300_0028;
        tick();
        repeat (7) tick();
        s_ready = 1'b1; s_rdata = 32'hCAFE_0001;
        #1;
        chk("t5_m0_ready", m0_ready, 1);
        chk("t5_m0_rdata", m0_rdata, 32'hCAFE_0001);
        tick();
        s_ready = 1'b0; s_rdata = '0; m0_valid = 1'b0;
        #1;
        chk("t5_no_err_ready", m0_ready, 0);
        chk("t5_s_valid", s_valid, 0);
        tick(); #1;
        chk("t5_tflag", timeout_flag, 0);

        // Reset while m1 owns the bus
        m1_valid = 1'b1; m1_addr = 32'h0300_002C;
        tick(); #1;
        chk("t6_gnt_s_valid", s_valid, 1);
        resetn = 1'b0;
        tick(); #1;
        chk("t6_rst_s_valid", s_valid, 0);
        chk("t6_rst_m1_ready", m1_ready, 0);
        m1_valid = 1'b0; resetn = 1'b1;
        m0_valid = 1'b1; m0_addr = 32'h0300_0030;
        tick(); #1;
        chk("t6_m0_s_valid", s_valid, 1);
        chk("t6_m0_s_addr", s_addr, 32'h0300_0030);
        s_ready = 1'b1; s_rdata = 32'h0000_0055;
        #1;
        chk("t6_m0_ready", m0_ready, 1);
        chk("t6_m0_rdata", m0_rdata, 32'h0000_0055);
        tick();
        s_ready = 1'b0; m0_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iomem_arbiter.md
Name: iomem_arbiter

Overview:
- Two-master, one-slave arbiter for the SoC iomem bus (valid/ready, 32-bit addr/data, 4-bit wstrb).
- Master 0 is the CPU iomem port; master 1 is a secondary requester (sensor DMA / debug).
- Grants round-robin, forwards the granted master's request to the peripheral slave (GPIO at 0x03xxxxxx and others).
- A bus watchdog completes stalled transfers with an error word.

Parameters:
- TIMEOUT_CYCLES, 255: cycles a granted transfer may wait for s_ready before forced completion; 0 disables the watchdog.
- ERR_RDATA, 32'hDEAD_BEEF: read data returned on a timed-out transfer.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- m0_valid  in  1  master 0 request; held until m0_ready
- m0_ready  out  1  master 0 one-cycle completion pulse
- m0_addr  in  32  master 0 address
- m0_wdata  in  32  master 0 write data
- m0_wstrb  in  4  master 0 byte strobes; 0 = read
- m0_rdata  out  32  master 0 read data, valid with m0_ready
- m1_valid, m1_ready, m1_addr, m1_wdata, m1_wstrb, m1_rdata: same as master 0, for master 1
- s_valid  out  1  slave request
- s_ready  in  1  slave completion pulse
- s_addr  out  32  slave address
- s_wdata  out  32  slave write data
- s_wstrb  out  4  slave byte strobes
- s_rdata  in  32  slave read data
- timeout_flag  out  1  sticky; set on any watchdog completion
- timeout_master  out  1  master index of the most recent timeout
- timeout_clr  in  1  clears timeout_flag

Behaviour:
- Reset (resetn=0 at posedge) and reset mid-transfer:
  - state=IDLE, last_grant=1 (master 0 wins first), watchdog counter=0.
  - timeout_flag=0, timeout_master=0.
  - In-flight transfer is abandoned; no ready is issued.
- States: IDLE, GNT0, GNT1, ERR0, ERR1.
- IDLE:
  - All s_* outputs are 0; m*_ready=0; m*_rdata=0.
  - Only m0_valid -> GNT0. Only m1_valid -> GNT1.
  - Both valid -> grant the master != last_grant; last_grant updates on entry to GNTx.
- GNTx:
  - s_valid/s_addr/s_wdata/s_wstrb = mx_* (combinational mux).
  - mx_ready = s_ready; mx_rdata = s_rdata. The other master sees ready=0, rdata=0.
  - s_ready=1 -> IDLE next cycle.
  - mx_valid drops without s_ready (abort) -> IDLE, no ready issued.
  - Watchdog increments each GNT cycle without s_ready. Reaching TIMEOUT_CYCLES -> ERRx; s_valid is forced 0 in that same cycle.
  - s_ready and watchdog expiry in the same cycle: s_ready wins (normal completion).
- ERRx (exactly one cycle):
  - mx_ready=1, mx_rdata=ERR_RDATA, s_valid=0.
  - timeout_flag<=1, timeout_master<=x.
  - Next state IDLE.
- Latency:
  - Request seen in IDLE at cycle N -> s_valid at N+1 -> master ready in the same cycle as s_ready -> IDLE the following cycle.
  - Minimum 1 cycle of added latency per transfer; no back-to-back grants without passing through IDLE.
- timeout_flag:
  - timeout_clr clears it.
  - Set has priority over a simultaneous clear.
- Watchdog counter:
  - Width $clog2(TIMEOUT_CYCLES+1), saturating; cleared on entry to GNTx.
  - TIMEOUT_CYCLES=0: never expires; GNTx waits indefinitely.
- The slave must not see s_valid in the cycle after its ready pulse; the IDLE pass-through guarantees this.

Decomposition:
- Shared package iomem_pkg:
  - state encoding enum.
  - IOMEM_AW=32, IOMEM_DW=32, IOMEM_SW=4.
  - Peripheral base constants (GPIO_BASE=8'h03).
- Sub-module: iomem_watchdog (counter + expiry compare, with clear/enable/expired ports).
- The arbiter FSM and muxes stay in the top module.

Test Plan:
- Single read: m0 read addr 0x0300_0000; slave returns 0x1234_5678 two cycles after s_valid -> m0_ready one cycle with m0_rdata=0x1234_5678; s_valid first seen 1 cycle after m0_valid.
- Simultaneous requests after reset: m0 and m1 both valid -> m0 granted first, m1 after m0 completes. Repeat with both valid -> m1 granted first (alternation).
- Write forwarding: m1 writes 0xA5A5_A5A5, wstrb=4'b0011 -> s_wdata/s_wstrb match exactly, m0 sees no ready, slave register bytes [15:0]=0xA5A5.
- Timeout: TIMEOUT_CYCLES=8, slave never readies on m0 read -> m0_ready at cycle 9 of grant with rdata=0xDEAD_BEEF; timeout_flag=1, timeout_master=0; timeout_clr clears the flag.
- Race: s_ready asserted in the exact expiry cycle -> normal completion with slave data; timeout_flag stays 0.
- Reset mid-grant: resetn=0 while in GNT1 -> next cycle s_valid=0, no m1_ready; after release, m0-only request is granted normally.
